// File: rtl/uart_boot_pkg.sv
// Shared definitions for the UART boot / image dump path.
//   BAUD_115200  : clocks per UART bit at 115200 baud
//   WORD_BYTES   : bytes per memory word on the wire
//   HDR_BYTES    : bytes in the length header
//   dump_state_t : states of the memory dump sequencer
package uart_boot_pkg;

  localparam logic [12:0] BAUD_115200 = 13'h01b2;
  localparam int          WORD_BYTES  = 4;
  localparam int          HDR_BYTES   = 2;

  typedef enum logic [3:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    RD_REQ,
    RD_WAIT,
    B3,
    B2,
    B1,
    B0,
    FIN
  } dump_state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, idle high.
//   clk, rst  : clock, synchronous active-high reset
//   trmt      : 1-cycle request to send tx_data (ignored while a frame is out)
//   tx_data   : byte to send, captured with trmt
//   baud_cnt  : clocks per bit
//   TX        : serial output, driven straight from a flop
//   tx_done   : 1-cycle pulse once the stop bit has completed
module uart_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        trmt,
  input  logic [7:0]  tx_data,
  input  logic [12:0] baud_cnt,
  output logic        TX,
  output logic        tx_done
);

  logic [9:0]  shift_q;
  logic [12:0] baud_q;
  logic [3:0]  bit_q;
  logic        active_q;
  logic        done_q;

  // NOTE: sequential state is written only with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '1;
      baud_q   <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!active_q) begin
        if (trmt) begin
          // Stop bit, data, start bit; shifting right puts bit 0 on the line first.
          shift_q  <= {1'b1, tx_data, 1'b0};
          baud_q   <= '0;
          bit_q    <= '0;
          active_q <= 1'b1;
        end
      end else if (baud_q == baud_cnt - 13'd1) begin
        baud_q  <= '0;
        // Shift in ones so the line rests high once the frame has drained.
        shift_q <= {1'b1, shift_q[9:1]};
        if (bit_q == 4'd9) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end else begin
          bit_q <= bit_q + 4'd1;
        end
      end else begin
        baud_q <= baud_q + 13'd1;
      end
    end
  end

  assign TX      = shift_q[0];
  assign tx_done = done_q;

endmodule

// File: rtl/uart_mem_dump.sv
// Streams a memory image out on a UART in the boot-loader frame format:
// 16-bit byte-count header MSB first, then 32-bit words MSB first.
//   clk, rst  : clock, synchronous active-high reset
//   start     : 1-cycle request, honoured only when idle
//   num_bytes : image length; low 2 bits are dropped on capture
//   re, raddr : 1-cycle memory read strobe and byte address
//   rdata     : read data, valid the cycle after re
//   TX        : UART serial output
//   busy      : high from accepted start until the dump completes
//   done      : 1-cycle pulse after the final stop bit
module uart_mem_dump
  import uart_boot_pkg::*;
#(
  parameter logic [12:0] BAUD_CNT = BAUD_115200,
  parameter int          ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       num_bytes,
  output logic              re,
  output logic [ADDR_W-1:0] raddr,
  input  logic [31:0]       rdata,
  output logic              TX,
  output logic              busy,
  output logic              done
);

  dump_state_t       state_q;
  logic [15:0]       nb_q;
  logic [ADDR_W-1:0] raddr_q;
  logic [ADDR_W-1:0] raddr_d;
  logic [ADDR_W-1:0] end_addr;
  logic [31:0]       word_q;
  logic [7:0]        tx_data_q;
  logic              re_q;
  logic              busy_q;
  logic              done_q;
  logic              trmt_q;
  logic              issue_q;
  logic              tx_done;

  assign raddr_d  = raddr_q + ADDR_W'(WORD_BYTES);
  assign end_addr = nb_q[ADDR_W-1:0];

  uart_tx u_tx (
    .clk      (clk),
    .rst      (rst),
    .trmt     (trmt_q),
    .tx_data  (tx_data_q),
    .baud_cnt (BAUD_CNT),
    .TX       (TX),
    .tx_done  (tx_done)
  );

  // issue_q marks a state entered without a frame launched yet (HDR_HI after start,
  // B3 after a read); every other byte is launched the cycle after tx_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      nb_q      <= '0;
      raddr_q   <= '0;
      word_q    <= '0;
      tx_data_q <= '0;
      re_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      trmt_q    <= 1'b0;
      issue_q   <= 1'b0;
    end else begin
      re_q   <= 1'b0;
      done_q <= 1'b0;
      trmt_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            // Word-granular length keeps the receiver's end compare reachable.
            nb_q    <= num_bytes & 16'hfffc;
            raddr_q <= '0;
            busy_q  <= 1'b1;
            issue_q <= 1'b1;
            state_q <= HDR_HI;
          end
        end
        HDR_HI: begin
          if (issue_q) begin
            issue_q   <= 1'b0;
            trmt_q    <= 1'b1;
            tx_data_q <= nb_q[15:8];
          end else if (tx_done) begin
            trmt_q    <= 1'b1;
            tx_data_q <= nb_q[7:0];
            state_q   <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (tx_done) begin
            if (raddr_q == end_addr) begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              re_q    <= 1'b1;
              state_q <= RD_REQ;
            end
          end
        end
        RD_REQ: state_q <= RD_WAIT;
        RD_WAIT: begin
          // rdata is only trusted here, one cycle after the read strobe.
          word_q  <= rdata;
          issue_q <= 1'b1;
          state_q <= B3;
        end
        B3: begin
          if (issue_q) begin
            issue_q   <= 1'b0;
            trmt_q    <= 1'b1;
            tx_data_q <= word_q[31:24];
          end else if (tx_done) begin
            trmt_q    <= 1'b1;
            tx_data_q <= word_q[23:16];
            state_q   <= B2;
          end
        end
        B2: begin
          if (tx_done) begin
            trmt_q    <= 1'b1;
            tx_data_q <= word_q[15:8];
            state_q   <= B1;
          end
        end
        B1: begin
          if (tx_done) begin
            trmt_q    <= 1'b1;
            tx_data_q <= word_q[7:0];
            state_q   <= B0;
          end
        end
        B0: begin
          if (tx_done) begin
            raddr_q <= raddr_d;
            if (raddr_d == end_addr) begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              re_q    <= 1'b1;
              state_q <= RD_REQ;
            end
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign re    = re_q;
  assign raddr = raddr_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_uart_mem_dump.sv
module tb_uart_mem_dump;

  localparam int B  = 16;  // short bit period keeps the run small
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   num_bytes;
  logic          re;
  logic [AW-1:0] raddr;
  logic [31:0]   rdata;
  logic          TX;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  uart_mem_dump #(.BAUD_CNT(13'(B)), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_bytes (num_bytes),
    .re        (re),
    .raddr     (raddr),
    .rdata     (rdata),
    .TX        (TX),
    .busy      (busy),
    .done      (done)
  );

  // Memory model: data valid only in the cycle after re, garbage otherwise.
  logic [31:0] mem [32];
  always @(posedge clk) rdata <= re ? mem[raddr[6:2]] : 32'h0bad0bad;

  // Monitors.
  logic [7:0] rx_q [$];
  int         addr_q [$];
  int         done_cnt;
  int         frame_err;

  always @(negedge clk) begin
    if (re)   addr_q.push_back(int'(raddr));
    if (done) done_cnt++;
  end

  // UART receiver model: samples mid-bit on the falling clock edge.
  initial begin : rx_model
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (TX === 1'b0) begin
        repeat (B / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          b[i] = TX;
        end
        repeat (B) @(negedge clk);
        if (TX !== 1'b1) frame_err++;
        rx_q.push_back(b);
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct packed {
    logic [15:0] nb;
    logic [79:0] stream;  // first byte in the top 8 bits
    logic [7:0]  len;
    logic [7:0]  reads;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs [NV];

  task automatic clear_mon();
    rx_q.delete();
    addr_q.delete();
    done_cnt  = 0;
    frame_err = 0;
  endtask

  // Leaves the caller at the falling edge right after the sampling edge.
  task automatic pulse_start(input logic [15:0] nb);
    @(negedge clk);
    num_bytes = nb;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, " idle"}, 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_rx(input string tag, input int count, input int budget);
    int n = 0;
    while (rx_q.size() < count && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, " rx progress"}, 32'(rx_q.size() >= count), 32'd1);
  endtask

  task automatic check_stream(input string tag, input vec_t v);
    check({tag, " len"}, rx_q.size(), 32'(v.len));
    for (int i = 0; i < int'(v.len); i++)
      if (i < rx_q.size())
        check($sformatf("%s byte%0d", tag, i), 32'(rx_q[i]), 32'(v.stream[79-8*i -: 8]));
    check({tag, " reads"}, addr_q.size(), 32'(v.reads));
    for (int i = 0; i < addr_q.size(); i++)
      check($sformatf("%s raddr%0d", tag, i), addr_q[i], 32'(4 * i));
    check({tag, " done pulses"}, done_cnt, 32'd1);
    check({tag, " framing"}, frame_err, 32'd0);
  endtask

  initial begin
    int   j;
    int   run;
    vec_t v4;

    vecs[0] = '{nb: 16'h0008, stream: {16'h0008, 32'hdeadbeef, 32'h01234567}, len: 8'd10, reads: 8'd2};
    vecs[1] = '{nb: 16'h0000, stream: {16'h0000, 64'h0},                      len: 8'd2,  reads: 8'd0};
    vecs[2] = '{nb: 16'h0006, stream: {16'h0004, 32'hdeadbeef, 32'h0},        len: 8'd6,  reads: 8'd1};
    vecs[3] = '{nb: 16'h0003, stream: {16'h0000, 64'h0},                      len: 8'd2,  reads: 8'd0};
    vecs[4] = '{nb: 16'h000b, stream: {16'h0008, 32'hdeadbeef, 32'h01234567}, len: 8'd10, reads: 8'd2};
    v4      = '{nb: 16'h0004, stream: {16'h0004, 32'hdeadbeef, 32'h0},        len: 8'd6,  reads: 8'd1};

    mem[0] = 32'hdeadbeef;
    mem[1] = 32'h01234567;
    for (int k = 2; k < 32; k++) mem[k] = 32'ha5000000 ^ (32'(k) * 32'h01030507);

    rst       = 1'b1;
    start     = 1'b0;
    num_bytes = '0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("reset TX",    32'(TX),    32'd1);
    check("reset busy",  32'(busy),  32'd0);
    check("reset done",  32'(done),  32'd0);
    check("reset re",    32'(re),    32'd0);
    check("reset raddr", 32'(raddr), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven dumps.
    for (int k = 0; k < NV; k++) begin
      clear_mon();
      pulse_start(vecs[k].nb);
      wait_idle($sformatf("vec%0d", k), (2 + int'(vecs[k].nb)) * 12 * B + 200);
      check_stream($sformatf("vec%0d", k), vecs[k]);
    end

    // Start-to-TX latency and exact bit period: header high byte 00 holds TX low
    // for the start bit plus eight zero data bits.
    clear_mon();
    pulse_start(16'h0008);
    j = 0;
    while (TX !== 1'b0 && j < 20) begin
      @(negedge clk);
      j++;
    end
    check("start to TX low edges", j, 32'd2);
    run = 0;
    while (TX === 1'b0 && run < 20 * B) begin
      @(negedge clk);
      run++;
    end
    check("header hi low run", run, 32'(9 * B));
    wait_idle("timing", 12 * 12 * B);

    // start re-pulsed while the third byte is on the wire is ignored.
    clear_mon();
    pulse_start(16'h0008);
    wait_rx("repulse", 2, 4 * 12 * B);
    repeat (3 * B) @(negedge clk);
    pulse_start(16'h0000);
    wait_idle("repulse", 12 * 12 * B);
    check_stream("repulse", vecs[0]);

    // Reset in a data bit of byte 5, then a clean 4-byte dump.
    clear_mon();
    pulse_start(16'h0008);
    wait_rx("midrst", 4, 6 * 12 * B);
    repeat (3 * B) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst TX",   32'(TX),   32'd1);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst re",   32'(re),   32'd0);
    rst = 1'b0;
    repeat (12 * B) @(negedge clk);
    check("midrst line idle", 32'(TX), 32'd1);
    clear_mon();
    pulse_start(16'h0004);
    wait_idle("after rst", 8 * 12 * B);
    check_stream("after rst", v4);

    // 64-byte image read back and reassembled into words.
    clear_mon();
    pulse_start(16'h0040);
    wait_idle("image", 70 * 12 * B);
    check("image len", rx_q.size(), 32'd66);
    check("image reads", addr_q.size(), 32'd16);
    check("image done pulses", done_cnt, 32'd1);
    if (rx_q.size() == 66) begin
      check("image hdr", {16'h0, rx_q[0], rx_q[1]}, 32'h0000_0040);
      for (int w = 0; w < 16; w++)
        check($sformatf("image word%0d", w),
              {rx_q[2+4*w], rx_q[3+4*w], rx_q[4+4*w], rx_q[5+4*w]}, mem[w]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
